// File: rtl/ram_output_reader.sv
// Drains the output RAM from address 0 upward and presents the words as an
// AXI-Stream master, keeping a tag pipeline in lockstep with the RAM's gated read path.
module ram_output_reader #(
   parameter int DEPTH      = 192,
   parameter int WIDTH      = 32,
   parameter int LATENCY    = 2,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rn,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [WIDTH-1:0]      ram_dout,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   n_q;
   logic [ADDR_WIDTH:0]   n_clamped;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LATENCY-1:0]    tag_v;
   logic [LATENCY-1:0]    tag_l;
   logic                  done_q, done_d;
   logic                  adv, accept, ins_v, ins_l, is_last, beat_last;

   assign n_clamped = (count > DEPTH_W) ? DEPTH_W : count;
   assign busy      = (state_q != IDLE);
   assign m_valid   = tag_v[LATENCY-1];
   assign m_last    = tag_l[LATENCY-1];
   assign m_data    = ram_dout;
   // Stalling only on a presented-but-unaccepted word keeps tags aligned with RAM data.
   assign adv       = busy & (~m_valid | m_ready);
   assign ram_en    = adv;
   assign ram_addr  = addr_q;
   assign done      = done_q;
   assign is_last   = ({1'b0, addr_q} == (n_q - ONE_W));
   assign beat_last = m_valid & m_ready & m_last;

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      accept  = 1'b0;
      ins_v   = 1'b0;
      ins_l   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (n_clamped == '0) done_d  = 1'b1;
               else                 state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (adv) begin
               ins_v = 1'b1;
               ins_l = is_last;
               if (is_last) state_d = FLUSH;
            end
         end
         FLUSH:   ;
         default: state_d = IDLE;
      endcase
      if (busy && beat_last) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         n_q    <= '0;
         addr_q <= '0;
         tag_v  <= '0;
         tag_l  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
         if (accept) begin
            n_q    <= n_clamped;
            addr_q <= '0;
         end else if (ins_v && !ins_l) begin
            addr_q <= addr_q + 1'b1;
         end
         // Final handshake retires the drain; FLUSH bubbles still in the tags are dropped.
         if (busy && beat_last) begin
            tag_v <= '0;
            tag_l <= '0;
         end else if (adv) begin
            for (int unsigned i = 1; i < LATENCY; i++) begin
               tag_v[i] <= tag_v[i-1];
               tag_l[i] <= tag_l[i-1];
            end
            tag_v[0] <= ins_v;
            tag_l[0] <= ins_l;
         end
      end
   end

endmodule

// File: tb/tb_ram_output_reader.sv
// Scoreboard bench for ram_output_reader: a gated-latency RAM model feeds the DUT and
// every accepted beat is checked against expected words queued when each start is driven.
module tb_ram_output_reader;

   localparam int DEPTH   = 192;
   localparam int WIDTH   = 32;
   localparam int LATENCY = 2;
   localparam int AW      = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rn;
   logic             start;
   logic [AW:0]      count;
   logic             busy, done, ram_en;
   logic [AW-1:0]    ram_addr;
   logic [WIDTH-1:0] ram_dout;
   logic [WIDTH-1:0] m_data;
   logic             m_valid, m_ready, m_last;

   ram_output_reader #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LATENCY), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rn(rn), .start(start), .count(count), .busy(busy), .done(done),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
   );

   always #5 clk = ~clk;

   // RAM model: data moves through its delay line only on enabled cycles
   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] rd_pipe [LATENCY];

   initial for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i * 3 + 1);

   always @(posedge clk) begin
      if (ram_en) begin
         rd_pipe[0] <= mem[ram_addr];
         for (int i = 1; i < LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end
   assign ram_dout = rd_pipe[LATENCY-1];

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } exp_t;
   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   int   cyc = 0;
   int   t0  = 0;
   int   first_rel, last_rel, done_rel, beats, done_cnt = 0, max_addr;
   bit   busy_seen, valid_seen;
   int   en_cnt [DEPTH];
   bit   prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data;
   logic             prev_last;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      int   rel;
      exp_t e;
      rel = cyc - t0;
      if (prev_stall) begin
         check("stall_valid", 64'(m_valid), 64'd1);
         check("stall_data", 64'(m_data), 64'(prev_data));
         check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
         beats++;
         check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("beat_data", 64'(m_data), 64'(e.data));
            check("beat_last", 64'(m_last), 64'(e.last));
         end
         if (m_last) last_rel = rel;
      end
      if (m_valid && first_rel < 0) first_rel = rel;
      if (done) begin
         done_rel = rel;
         done_cnt++;
      end
      if (busy)    busy_seen  = 1'b1;
      if (m_valid) valid_seen = 1'b1;
      if (ram_en) begin
         if (int'(ram_addr) < DEPTH) en_cnt[ram_addr]++;
         if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
   end

   // Drives start for the current cycle and queues the words an accepted drain must produce.
   task automatic issue_start(input int cnt);
      int n;
      start = 1'b1;
      count = (AW+1)'(cnt);
      t0    = cyc;
      first_rel = -1; last_rel = -1; done_rel = -1; beats = 0; max_addr = 0;
      busy_seen = 1'b0; valid_seen = 1'b0;
      foreach (en_cnt[i]) en_cnt[i] = 0;
      n = (cnt > DEPTH) ? DEPTH : cnt;
      for (int i = 0; i < n; i++) sb.push_back({WIDTH'(i * 3 + 1), 1'(i == n - 1)});
   endtask

   task automatic start_drain(input int cnt);
      @(posedge clk); #1;
      issue_start(cnt);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd);
      int base;
      int k;
      base = done_cnt;
      k = 0;
      while (done_cnt == base && k < budget) begin
         @(posedge clk); #1;
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         k++;
      end
      m_ready = 1'b1;
      check("done_timeout", 64'(done_cnt != base), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int errs;
      rn = 1'b0; start = 1'b0; count = '0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_en", 64'(ram_en), 64'd0);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_addr", 64'(ram_addr), 64'd0);
      rn = 1'b1;

      // full drain, no backpressure
      start_drain(192);
      wait_done(400, 1'b0);
      check("full_first", 64'(first_rel), 64'd3);
      check("full_last", 64'(last_rel), 64'd194);
      check("full_done", 64'(done_rel), 64'd195);
      check("full_beats", 64'(beats), 64'd192);
      errs = 0;
      for (int i = 0; i < DEPTH - 1; i++) if (en_cnt[i] != 1) errs++;
      check("full_en_once", 64'(errs), 64'd0);
      check("full_en_top", 64'(en_cnt[DEPTH-1] >= 1), 64'd1);
      check("full_sb_empty", 64'(sb.size()), 64'd0);

      // random backpressure
      start_drain(64);
      wait_done(2000, 1'b1);
      check("rnd_beats", 64'(beats), 64'd64);
      check("rnd_done_after_last", 64'(done_rel), 64'(last_rel + 1));
      check("rnd_sb_empty", 64'(sb.size()), 64'd0);

      // single word and empty drains
      start_drain(1);
      wait_done(20, 1'b0);
      check("one_first", 64'(first_rel), 64'd3);
      check("one_last", 64'(last_rel), 64'd3);
      check("one_done", 64'(done_rel), 64'd4);
      check("one_beats", 64'(beats), 64'd1);
      start_drain(0);
      wait_done(20, 1'b0);
      check("zero_done", 64'(done_rel), 64'd1);
      check("zero_busy", 64'(busy_seen), 64'd0);
      check("zero_valid", 64'(valid_seen), 64'd0);

      // clamp, ignored start while busy, back-to-back start in the done cycle
      start_drain(300);
      while (cyc - t0 < 195) begin
         @(posedge clk); #1;
         if (cyc - t0 == 50) begin start = 1'b1; count = (AW+1)'(5); end
         if (cyc - t0 == 51) start = 1'b0;
      end
      check("clamp_beats", 64'(beats), 64'd192);
      check("clamp_max_addr", 64'(max_addr), 64'd191);
      check("clamp_done_cycle", 64'(done), 64'd1);
      issue_start(2);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(20, 1'b0);
      check("b2b_beats", 64'(beats), 64'd2);
      check("b2b_done", 64'(done_rel), 64'd5);
      check("b2b_sb_empty", 64'(sb.size()), 64'd0);

      // asynchronous reset mid-drain
      start_drain(100);
      while (cyc - t0 < 20) @(posedge clk);
      #1;
      rn = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_en", 64'(ram_en), 64'd0);
      check("mid_rst_valid", 64'(m_valid), 64'd0);
      check("mid_rst_last", 64'(m_last), 64'd0);
      check("mid_rst_addr", 64'(ram_addr), 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rn = 1'b1;
      start_drain(4);
      wait_done(30, 1'b0);
      check("post_rst_beats", 64'(beats), 64'd4);
      check("post_rst_last", 64'(last_rel), 64'd6);
      check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
